// File: rtl/sync_filter_pkg.sv
// sync_filter_pkg: shared constants and helpers for the sync_filter block.
// Optional edge outputs are controlled by the SYNC_FILTER_EDGE_EN macro.
package sync_filter_pkg;

    // Fewest flops that still give a metastable first stage a full cycle to settle.
    localparam int SYNC_MIN_STAGES = 2;

    // Width of the per-bit stability counter. It never drops below one bit, so
    // FILTER_LEN = 1 still yields a legal vector.
    function automatic int cnt_width(input int filter_len);
        int w;
        w = $clog2(filter_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filter_if.sv
// sync_filter_if: bundles the asynchronous input bus and the filtered outputs.
// The rise/fall vectors exist only when SYNC_FILTER_EDGE_EN is defined.
interface sync_filter_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] i_in;       // asynchronous input levels
    logic [WIDTH-1:0] o_out;      // filtered, synchronized levels
    logic             o_changed;  // one-cycle pulse when any o_out bit updates
`ifdef SYNC_FILTER_EDGE_EN
    logic [WIDTH-1:0] o_rise;     // per-bit 0->1 pulse
    logic [WIDTH-1:0] o_fall;     // per-bit 1->0 pulse
`endif

`ifdef SYNC_FILTER_EDGE_EN
    // Source of the asynchronous levels and consumer of the filtered result.
    modport master (
        output i_in,
        input  o_out,
        input  o_changed,
        input  o_rise,
        input  o_fall
    );

    // The filter itself.
    modport slave (
        input  i_in,
        output o_out,
        output o_changed,
        output o_rise,
        output o_fall
    );
`else
    // Source of the asynchronous levels and consumer of the filtered result.
    modport master (
        output i_in,
        input  o_out,
        input  o_changed
    );

    // The filter itself.
    modport slave (
        input  i_in,
        output o_out,
        output o_changed
    );
`endif

endinterface

// File: rtl/sync_filter_bit.sv
// sync_filter_bit: one bit of the filter -- synchronizer chain, stability
// counter, output flop and change/edge flags. Edge flags are built only when
// SYNC_FILTER_EDGE_EN is defined.
module sync_filter_bit
    import sync_filter_pkg::*;
#(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 4,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_in,
    output logic o_out,
    output logic o_changed
`ifdef SYNC_FILTER_EDGE_EN
    ,
    output logic o_rise,
    output logic o_fall
`endif
);

    localparam int             CNT_W   = cnt_width(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [STAGES-1:0] r_sync;
    logic              w_synced;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out;
    logic              r_changed;
    logic              w_accept;

    assign w_synced = r_sync[STAGES-1];

    // A new level is taken on the edge where it has differed from the current
    // output for FILTER_LEN consecutive edges, this one included.
    assign w_accept = (w_synced != r_out) && (r_cnt == CNT_MAX);

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every stage load the pre-edge
        // value of its neighbour, so data moves exactly one stage per clock.
        if (!resetn) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_in};
        end
    end

    // Count consecutive cycles of disagreement; any agreement discards credit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_synced == r_out) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Output level and its change flag update together on acceptance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out     <= RESET_VAL;
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_accept;
            if (w_accept) begin
                r_out <= w_synced;
            end
        end
    end

    assign o_out     = r_out;
    assign o_changed = r_changed;

`ifdef SYNC_FILTER_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Direction flags, aligned with the change flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept &  w_synced;
            r_fall <= w_accept & ~w_synced;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`endif

endmodule

// File: rtl/sync_filter.sv
// sync_filter: WIDTH independent synchronizer + glitch-filter slices. The
// per-bit change flags are ORed into a single o_changed pulse.
// Defining SYNC_FILTER_EDGE_EN adds per-bit o_rise/o_fall pulse vectors.
module sync_filter
    import sync_filter_pkg::*;
#(
    parameter int             WIDTH      = 8,
    parameter int             STAGES     = 2,
    parameter int             FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic        clk,
    input  logic        resetn,
    sync_filter_if.slave bus
);

    // Reject configurations that cannot synchronize or filter.
    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_filter: STAGES must be at least SYNC_MIN_STAGES");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("sync_filter: FILTER_LEN must be at least 1");
    end

    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] w_changed;
`ifdef SYNC_FILTER_EDGE_EN
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
`endif

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        sync_filter_bit #(
            .STAGES     (STAGES),
            .FILTER_LEN (FILTER_LEN),
            .RESET_VAL  (RESET_VAL[gi])
        ) u_bit (
            .clk       (clk),
            .resetn    (resetn),
            .i_in      (bus.i_in[gi]),
            .o_out     (w_out[gi]),
            .o_changed (w_changed[gi])
`ifdef SYNC_FILTER_EDGE_EN
            ,
            .o_rise    (w_rise[gi]),
            .o_fall    (w_fall[gi])
`endif
        );
    end

    assign bus.o_out     = w_out;
    assign bus.o_changed = |w_changed;
`ifdef SYNC_FILTER_EDGE_EN
    assign bus.o_rise    = w_rise;
    assign bus.o_fall    = w_fall;
`endif

endmodule
